cpu_controller: RTL and testbench

CPU_CONTROLLER -- requirements
Module: cpu_controller

---
 rtl/cpu_controller.sv | 173 +++++++++++++++++
 tb/tb_cpu_controller.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/cpu_controller.sv
// Purpose : Moore FSM sequencing the simple-CPU datapath (read, ALU, writeback) from a 16-bit instruction register.
// Latency : s sampled in WAIT -> busy (w=0) for 1..5 cycles depending on instruction, then back to WAIT.
// Backpr. : none; s and load are honoured in WAIT only and ignored in every other state.
//
// Ports: clk, rst_n (async active-low); s (start), load (IR capture), in[15:0] (instruction word);
//        w (idle/halted), readnum/writenum (register selects), vsel/shift/ALUop (2-bit selects),
//        write/loada/loadb/loadc/loads/asel/bsel (strobes/selects), sximm8/sximm5 (sign-extended IR fields).
// Build option: define CPU_CONTROLLER_HALT_EN to add a HALT state entered by opcode 111
//        (left only by reset); without it opcode 111 decodes as illegal.
module cpu_controller (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        s,
    input  logic        load,
    input  logic [15:0] in,
    output logic        w,
    output logic [2:0]  readnum,
    output logic [2:0]  writenum,
    output logic [1:0]  vsel,
    output logic [1:0]  shift,
    output logic [1:0]  ALUop,
    output logic        write,
    output logic        loada,
    output logic        loadb,
    output logic        loadc,
    output logic        loads,
    output logic        asel,
    output logic        bsel,
    output logic [15:0] sximm8,
    output logic [15:0] sximm5
);

    typedef enum logic [2:0] {
        ST_WAIT      = 3'd0,
        ST_DECODE    = 3'd1,
        ST_WRITE_IMM = 3'd2,
        ST_GET_A     = 3'd3,
        ST_GET_B     = 3'd4,
        ST_ALU       = 3'd5,
`ifdef CPU_CONTROLLER_HALT_EN
        ST_WRITE_REG = 3'd6,
        ST_HALT      = 3'd7
`else
        ST_WRITE_REG = 3'd6
`endif
    } state_t;

    state_t      state_q, state_d;
    logic [15:0] ir_q, ir_d;

    // Instruction fields
    logic [2:0] opcode;
    logic [1:0] op;
    logic [2:0] rn, rd, rm;
    logic [1:0] sh;
    logic [4:0] opc_op;

    assign opcode = ir_q[15:13];
    assign op     = ir_q[12:11];
    assign rn     = ir_q[10:8];
    assign rd     = ir_q[7:5];
    assign sh     = ir_q[4:3];
    assign rm     = ir_q[2:0];
    assign opc_op = {opcode, op};

    assign sximm8 = {{8{ir_q[7]}}, ir_q[7:0]};
    assign sximm5 = {{11{ir_q[4]}}, ir_q[4:0]};

    // State and IR registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_WAIT;
            ir_q    <= 16'h0000;
        end else begin
            state_q <= state_d;
            ir_q    <= ir_d;
        end
    end

    // Next state and IR capture. DECODE looks at ir_q one cycle after the
    // s edge, so a load on that same edge is already visible to it.
    always_comb begin
        state_d = state_q;
        ir_d    = ir_q;
        case (state_q)
            ST_WAIT: begin
                if (load) ir_d = in;
                if (s)    state_d = ST_DECODE;
            end
            ST_DECODE: begin
                state_d = ST_WAIT;
`ifdef CPU_CONTROLLER_HALT_EN
                if (opcode == 3'b111) begin
                    state_d = ST_HALT;
                end else
`endif
                begin
                    case (opc_op)
                        5'b110_10:                      state_d = ST_WRITE_IMM;
                        5'b110_00, 5'b101_11:           state_d = ST_GET_B;
                        5'b101_00, 5'b101_01, 5'b101_10: state_d = ST_GET_A;
                        default:                        state_d = ST_WAIT;
                    endcase
                end
            end
            ST_WRITE_IMM: state_d = ST_WAIT;
            ST_GET_A:     state_d = ST_GET_B;
            ST_GET_B:     state_d = ST_ALU;
            // CMP only updates status; nothing to write back
            ST_ALU:       state_d = (opc_op == 5'b101_01) ? ST_WAIT : ST_WRITE_REG;
            ST_WRITE_REG: state_d = ST_WAIT;
`ifdef CPU_CONTROLLER_HALT_EN
            ST_HALT:      state_d = ST_HALT;
`endif
            default:      state_d = ST_WAIT;
        endcase
    end

    // Moore outputs
    always_comb begin
        w        = 1'b0;
        readnum  = 3'd0;
        writenum = 3'd0;
        vsel     = 2'b00;
        shift    = 2'b00;
        ALUop    = 2'b00;
        write    = 1'b0;
        loada    = 1'b0;
        loadb    = 1'b0;
        loadc    = 1'b0;
        loads    = 1'b0;
        asel     = 1'b0;
        bsel     = 1'b0;
        case (state_q)
            ST_WAIT: w = 1'b1;
            ST_WRITE_IMM: begin
                writenum = rn;
                vsel     = 2'b01;
                write    = 1'b1;
            end
            ST_GET_A: begin
                readnum = rn;
                loada   = 1'b1;
            end
            ST_GET_B: begin
                readnum = rm;
                loadb   = 1'b1;
            end
            ST_ALU: begin
                shift = sh;
                // MOV Rd,Rm: zero the A side and ADD so the shifted B passes through
                if (opc_op == 5'b110_00) begin
                    asel  = 1'b1;
                    ALUop = 2'b00;
                end else begin
                    ALUop = op;
                end
                if (opc_op == 5'b101_01) loads = 1'b1;
                else                     loadc = 1'b1;
            end
            ST_WRITE_REG: begin
                writenum = rd;
                vsel     = 2'b11;
                write    = 1'b1;
            end
`ifdef CPU_CONTROLLER_HALT_EN
            ST_HALT: w = 1'b1;
`endif
            default: ;
        endcase
    end

endmodule

// File: tb/tb_cpu_controller.sv
module tb_cpu_controller;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        s, load;
    logic [15:0] in;
    logic        w;
    logic [2:0]  readnum, writenum;
    logic [1:0]  vsel, shift, ALUop;
    logic        write, loada, loadb, loadc, loads, asel, bsel;
    logic [15:0] sximm8, sximm5;

    cpu_controller dut (
        .clk(clk), .rst_n(rst_n), .s(s), .load(load), .in(in),
        .w(w), .readnum(readnum), .writenum(writenum),
        .vsel(vsel), .shift(shift), .ALUop(ALUop),
        .write(write), .loada(loada), .loadb(loadb), .loadc(loadc),
        .loads(loads), .asel(asel), .bsel(bsel),
        .sximm8(sximm8), .sximm5(sximm5)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        w;
        logic [2:0]  readnum;
        logic [2:0]  writenum;
        logic [1:0]  vsel;
        logic [1:0]  shift;
        logic [1:0]  aluop;
        logic        write;
        logic        loada;
        logic        loadb;
        logic        loadc;
        logic        loads;
        logic        asel;
        logic        bsel;
        logic [15:0] sximm8;
        logic [15:0] sximm5;
    } rec_t;

    rec_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    // Record with every strobe low; w high when idle. Immediates from plain arithmetic.
    function automatic rec_t idle_rec(input logic [15:0] i, input bit busy);
        rec_t r;
        int   v8, v5;
        r    = '0;
        r.w  = !busy;
        v8   = int'(i[7:0]);
        if (v8 > 127) v8 = v8 - 256;
        v5   = int'(i[4:0]);
        if (v5 > 15) v5 = v5 - 32;
        r.sximm8 = v8[15:0];
        r.sximm5 = v5[15:0];
        return r;
    endfunction

    // Busy-cycle count per instruction class
    function automatic int busy_cycles(input logic [15:0] i);
        case ({i[15:13], i[12:11]})
            5'b110_10:                       return 2;
            5'b101_01:                       return 4;
            5'b110_00, 5'b101_11:            return 4;
            5'b101_00, 5'b101_10:            return 5;
            default:                         return 1;
        endcase
    endfunction

    // Reference: per-instruction list of expected per-cycle outputs, then the return to WAIT
    task automatic push_model(input logic [15:0] i);
        rec_t       r;
        logic [2:0] opc;
        logic [1:0] op;
        bit         movi, movr, mvn, cmp, two_src;
        opc     = i[15:13];
        op      = i[12:11];
        movi    = (opc == 3'b110) && (op == 2'b10);
        movr    = (opc == 3'b110) && (op == 2'b00);
        mvn     = (opc == 3'b101) && (op == 2'b11);
        cmp     = (opc == 3'b101) && (op == 2'b01);
        two_src = (opc == 3'b101) && (op != 2'b11);
        exp_q.push_back(idle_rec(i, 1));
        if (movi) begin
            r = idle_rec(i, 1); r.writenum = i[10:8]; r.vsel = 2'b01; r.write = 1'b1;
            exp_q.push_back(r);
        end else if (movr || mvn || two_src) begin
            if (two_src) begin
                r = idle_rec(i, 1); r.readnum = i[10:8]; r.loada = 1'b1;
                exp_q.push_back(r);
            end
            r = idle_rec(i, 1); r.readnum = i[2:0]; r.loadb = 1'b1;
            exp_q.push_back(r);
            r = idle_rec(i, 1); r.shift = i[4:3]; r.asel = movr;
            r.aluop = movr ? 2'b00 : op; r.loads = cmp; r.loadc = !cmp;
            exp_q.push_back(r);
            if (!cmp) begin
                r = idle_rec(i, 1); r.writenum = i[7:5]; r.vsel = 2'b11; r.write = 1'b1;
                exp_q.push_back(r);
            end
        end
        exp_q.push_back(idle_rec(i, 0));
    endtask

    // Monitor: every DUT cycle is checked against the next expected record
    rec_t got, e;
    always @(negedge clk) begin
        got = '{w: w, readnum: readnum, writenum: writenum, vsel: vsel, shift: shift,
                aluop: ALUop, write: write, loada: loada, loadb: loadb, loadc: loadc,
                loads: loads, asel: asel, bsel: bsel, sximm8: sximm8, sximm5: sximm5};
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks++;
            if (got !== e) begin
                errors++;
                $display("FAIL outputs @%0t: got=%h expected=%h", $time, got, e);
            end
        end else if (w !== 1'b1) begin
            checks++;
            errors++;
            $display("FAIL unexpected_busy @%0t: w=%b expected 1", $time, w);
        end
    end

    // Called at posedge+1 with the DUT in WAIT
    task automatic run_instr(input logic [15:0] i, input bit same_cycle, input bit junk_ones);
        int n;
        if (!same_cycle) begin
            s = 1'b0; load = 1'b1; in = i;
            @(posedge clk); #1;
            load = 1'b0; in = 16'($urandom);
            exp_q.push_back(idle_rec(i, 0));
        end
        s = 1'b1;
        if (same_cycle) begin load = 1'b1; in = i; end
        @(posedge clk); #1;
        push_model(i);
        n = busy_cycles(i);
        for (int k = 0; k < n; k++) begin
            s    = 1'($urandom_range(0, 1));
            load = junk_ones ? 1'b1 : 1'($urandom_range(0, 1));
            in   = junk_ones ? 16'hFFFF : 16'($urandom);
            @(posedge clk); #1;
        end
        s = 1'b0; load = 1'b0;
    endtask

    task automatic reset_mid_alu();
        s = 1'b1; load = 1'b1; in = 16'hA148;
        @(posedge clk); #1;
        s = 1'b0; load = 1'b0;
        push_model(16'hA148);
        while (exp_q.size() > 3) void'(exp_q.pop_back());
        @(posedge clk); #1;
        @(posedge clk); #1;
        @(posedge clk); #2;
        rst_n = 1'b0;
        exp_q.push_back(idle_rec(16'h0000, 0));
        @(posedge clk); #1;
        exp_q.push_back(idle_rec(16'h0000, 0));
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    logic [15:0] ri;
    initial begin
        rst_n = 1'b0; s = 1'b1; load = 1'b1; in = 16'hFFFF;
        exp_q.push_back(idle_rec(16'h0000, 0));
        @(posedge clk); #1;
        exp_q.push_back(idle_rec(16'h0000, 0));
        @(posedge clk); #1;
        rst_n = 1'b1; s = 1'b0; load = 1'b0;

        run_instr(16'hD0FB, 1, 0);   // MOV R0,#-5
        run_instr(16'hA148, 0, 0);   // ADD R2,R1,R0 LSL#1
        run_instr(16'hA900, 1, 0);   // CMP R1,R0
        run_instr(16'hB860, 0, 0);   // MVN R3,R0
        run_instr(16'hC090, 1, 1);   // MOV R4,R0 LSR, load=1/in=FFFF while busy
        run_instr(16'hB000, 1, 0);   // AND
        run_instr(16'hC800, 1, 0);   // illegal 110_01
        reset_mid_alu();
        run_instr(16'hD2AA, 0, 0);

        for (int t = 0; t < 80; t++) begin
            ri = 16'($urandom);
            case ($urandom_range(0, 3))
                0: ri[15:13] = 3'b101;
                1: ri[15:13] = 3'b110;
                2: ri[15:11] = 5'b110_10;
                default: ;
            endcase
`ifdef CPU_CONTROLLER_HALT_EN
            if (ri[15:13] == 3'b111) ri[15:13] = 3'b000;
`endif
            run_instr(ri, 1'($urandom_range(0, 1)), 0);
        end

`ifdef CPU_CONTROLLER_HALT_EN
        s = 1'b1; load = 1'b1; in = 16'hE000;
        @(posedge clk); #1;
        exp_q.push_back(idle_rec(16'hE000, 1));
        for (int k = 0; k < 8; k++) exp_q.push_back(idle_rec(16'hE000, 0));
        for (int k = 0; k < 9; k++) begin
            s = 1'($urandom_range(0, 1)); load = 1'b1; in = 16'($urandom);
            @(posedge clk); #1;
        end
        s = 1'b0; load = 1'b0;
`else
        run_instr(16'hE000, 1, 0);
`endif

        for (int t = 0; t < 50 && exp_q.size() > 0; t++) @(negedge clk);
        @(negedge clk);
        if (exp_q.size() > 0) begin
            checks++;
            errors++;
            $display("FAIL drain: %0d expected records left, required 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
